// File: rtl/ram_req_issuer.sv
// ram_req_issuer: buffers core read/write requests in a small FIFO and issues
// them one at a time to the RAM timing model, returning a one-cycle response
// with read data or a timeout error.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   req_valid/req_ready/req_we/
//   req_addr/req_wdata               core-side request (valid/ready)
//   resp_valid/resp_we/resp_err/
//   resp_rdata                       one-cycle response pulse
//   mem_rvalid/mem_raddr             read request to model
//   mem_wvalid/mem_waddr/mem_wdata   write request to model
//   mem_read_ready/mem_write_ready   model can accept read/write
//   mem_readfin/mem_writefin         model completion levels
//   mem_rdata                        model read data

package ram_req_issuer_pkg;

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } req_t;

endpackage

module ram_req_issuer
  import ram_req_issuer_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_we,
  output logic        resp_err,
  output logic [63:0] resp_rdata,
  output logic        mem_rvalid,
  output logic        mem_wvalid,
  output logic [63:0] mem_raddr,
  output logic [63:0] mem_waddr,
  output logic [63:0] mem_wdata,
  input  logic        mem_read_ready,
  input  logic        mem_write_ready,
  input  logic        mem_readfin,
  input  logic        mem_writefin,
  input  logic [63:0] mem_rdata
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_RD,
    S_WAIT_RD,
    S_ISSUE_WR,
    S_WAIT_WR,
    S_RESP
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  req_t          r_fifo [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  req_t          w_head;

  logic          r_rfin_q;
  logic          r_wfin_q;
  logic          w_rfin_rise;
  logic          w_wfin_rise;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_timeout;

  logic          r_mem_rvalid;
  logic          r_mem_wvalid;
  logic [63:0]   r_mem_raddr;
  logic [63:0]   r_mem_waddr;
  logic [63:0]   r_mem_wdata;
  logic          r_resp_valid;
  logic          r_resp_we;
  logic          r_resp_err;
  logic [63:0]   r_resp_rdata;

  logic          w_rvalid_nxt;
  logic          w_wvalid_nxt;
  logic          w_resp_valid_nxt;
  logic          w_resp_we_nxt;
  logic          w_resp_err_nxt;
  logic [63:0]   w_resp_rdata_nxt;

  // Full when the pointers differ only in their wrap bit.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = req_valid && !w_full;
  assign w_head  = r_fifo[r_rd_ptr[AW-1:0]];

  assign w_rfin_rise = mem_readfin  && !r_rfin_q;
  assign w_wfin_rise = mem_writefin && !r_wfin_q;
  assign w_timeout   = (r_cnt == CW'(TIMEOUT - 1));

  assign req_ready  = !w_full;
  assign resp_valid = r_resp_valid;
  assign resp_we    = r_resp_we;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign mem_rvalid = r_mem_rvalid;
  assign mem_wvalid = r_mem_wvalid;
  assign mem_raddr  = r_mem_raddr;
  assign mem_waddr  = r_mem_waddr;
  assign mem_wdata  = r_mem_wdata;

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr[AW-1:0]] <= req_t'{we: req_we, addr: req_addr, wdata: req_wdata};
    end
  end

  // Next state and next values of the registered outputs.
  always_comb begin
    w_state_nxt      = r_state;
    w_pop            = 1'b0;
    w_cnt_nxt        = r_cnt;
    w_rvalid_nxt     = 1'b0;
    w_wvalid_nxt     = 1'b0;
    w_resp_valid_nxt = 1'b0;
    w_resp_we_nxt    = 1'b0;
    w_resp_err_nxt   = 1'b0;
    w_resp_rdata_nxt = '0;

    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_cnt_nxt = '0;
          if (w_head.we) begin
            w_state_nxt  = S_ISSUE_WR;
            w_wvalid_nxt = 1'b1;
          end else begin
            w_state_nxt  = S_ISSUE_RD;
            w_rvalid_nxt = 1'b1;
          end
        end
      end

      S_ISSUE_RD: begin
        w_cnt_nxt = r_cnt + CW'(1);
        if (w_timeout) begin
          w_state_nxt      = S_RESP;
          w_resp_valid_nxt = 1'b1;
          w_resp_err_nxt   = 1'b1;
        end else if (mem_read_ready) begin
          w_state_nxt = S_WAIT_RD;
        end else begin
          w_rvalid_nxt = 1'b1;
        end
      end

      S_WAIT_RD: begin
        w_cnt_nxt = r_cnt + CW'(1);
        // A completion edge beats a coincident timeout.
        if (w_rfin_rise) begin
          w_state_nxt      = S_RESP;
          w_resp_valid_nxt = 1'b1;
          w_resp_rdata_nxt = mem_rdata;
        end else if (w_timeout) begin
          w_state_nxt      = S_RESP;
          w_resp_valid_nxt = 1'b1;
          w_resp_err_nxt   = 1'b1;
        end
      end

      S_ISSUE_WR: begin
        w_cnt_nxt     = r_cnt + CW'(1);
        w_resp_we_nxt = 1'b1;
        if (w_timeout) begin
          w_state_nxt      = S_RESP;
          w_resp_valid_nxt = 1'b1;
          w_resp_err_nxt   = 1'b1;
        end else if (mem_write_ready) begin
          w_state_nxt = S_WAIT_WR;
        end else begin
          w_wvalid_nxt = 1'b1;
        end
      end

      S_WAIT_WR: begin
        w_cnt_nxt     = r_cnt + CW'(1);
        w_resp_we_nxt = 1'b1;
        if (w_wfin_rise) begin
          w_state_nxt      = S_RESP;
          w_resp_valid_nxt = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt      = S_RESP;
          w_resp_valid_nxt = 1'b1;
          w_resp_err_nxt   = 1'b1;
        end
      end

      S_RESP: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Response fields are meaningful only alongside resp_valid.
    if (!w_resp_valid_nxt) begin
      w_resp_we_nxt = 1'b0;
    end
  end

  // State, pointers, edge history, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_rfin_q     <= 1'b0;
      r_wfin_q     <= 1'b0;
      r_cnt        <= '0;
      r_mem_rvalid <= 1'b0;
      r_mem_wvalid <= 1'b0;
      r_mem_raddr  <= '0;
      r_mem_waddr  <= '0;
      r_mem_wdata  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_we    <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_rfin_q     <= mem_readfin;
      r_wfin_q     <= mem_writefin;
      r_cnt        <= w_cnt_nxt;
      r_mem_rvalid <= w_rvalid_nxt;
      r_mem_wvalid <= w_wvalid_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_we    <= w_resp_we_nxt;
      r_resp_err   <= w_resp_err_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      // Popped head becomes the in-flight request; fields hold until the next pop.
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
        if (w_head.we) begin
          r_mem_waddr <= w_head.addr;
          r_mem_wdata <= w_head.wdata;
        end else begin
          r_mem_raddr <= w_head.addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_req_issuer.sv
// Bench for ram_req_issuer: transaction-level reference model compared against
// every output each cycle, plus directed scenarios with literal expectations.
module tb_ram_req_issuer;
  import ram_req_issuer_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_we;
  logic        resp_err;
  logic [63:0] resp_rdata;
  logic        mem_rvalid;
  logic        mem_wvalid;
  logic [63:0] mem_raddr;
  logic [63:0] mem_waddr;
  logic [63:0] mem_wdata;
  logic        mem_read_ready;
  logic        mem_write_ready;
  logic        mem_readfin;
  logic        mem_writefin;
  logic [63:0] mem_rdata;

  ram_req_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_we         (resp_we),
    .resp_err        (resp_err),
    .resp_rdata      (resp_rdata),
    .mem_rvalid      (mem_rvalid),
    .mem_wvalid      (mem_wvalid),
    .mem_raddr       (mem_raddr),
    .mem_waddr       (mem_waddr),
    .mem_wdata       (mem_wdata),
    .mem_read_ready  (mem_read_ready),
    .mem_write_ready (mem_write_ready),
    .mem_readfin     (mem_readfin),
    .mem_writefin    (mem_writefin),
    .mem_rdata       (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tfail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got no event want event within bound (cycle %0d)", nm, cyc);
  endtask

  // ---------------- reference model ----------------
  // Pending requests live in mq; one request at a time is in flight, tracked by
  // its age since issue and whether the model has taken it yet.
  req_t        mq[$];
  req_t        m_cur;
  bit          m_on   = 1'b0;
  bit          m_busy = 1'b0;
  bit          m_acc  = 1'b0;
  bit          m_resp = 1'b0;
  bit          m_fr   = 1'b0;
  bit          m_fw   = 1'b0;
  int          m_age  = 0;
  logic [63:0] e_raddr = '0;
  logic [63:0] e_waddr = '0;
  logic [63:0] e_wdata = '0;
  logic [63:0] e_rdata = '0;
  bit          e_err  = 1'b0;
  bit          e_we   = 1'b0;

  always @(posedge clk) begin
    bit take;
    bit fin;
    bit prev;
    bit rdy;
    cyc++;
    if (rst) begin
      mq.delete();
      m_busy = 1'b0; m_acc = 1'b0; m_resp = 1'b0; m_age = 0;
      m_fr = 1'b0; m_fw = 1'b0;
      e_raddr = '0; e_waddr = '0; e_wdata = '0; e_rdata = '0;
      e_err = 1'b0; e_we = 1'b0;
      m_on = 1'b1;
    end else begin
      take = req_valid && (mq.size() < int'(DEPTH));
      e_err = 1'b0; e_we = 1'b0; e_rdata = '0;
      if (m_resp) begin
        m_resp = 1'b0;
      end else if (!m_busy) begin
        if (mq.size() > 0) begin
          m_cur  = mq.pop_front();
          m_busy = 1'b1; m_acc = 1'b0; m_age = 0;
          if (m_cur.we) begin
            e_waddr = m_cur.addr;
            e_wdata = m_cur.wdata;
          end else begin
            e_raddr = m_cur.addr;
          end
        end
      end else begin
        fin  = m_cur.we ? mem_writefin    : mem_readfin;
        prev = m_cur.we ? m_fw            : m_fr;
        rdy  = m_cur.we ? mem_write_ready : mem_read_ready;
        if (m_acc && fin && !prev) begin
          m_busy = 1'b0; m_resp = 1'b1; e_we = m_cur.we;
          e_rdata = m_cur.we ? 64'd0 : mem_rdata;
        end else if (m_age == int'(TIMEOUT) - 1) begin
          m_busy = 1'b0; m_resp = 1'b1; e_we = m_cur.we; e_err = 1'b1;
        end else begin
          if (rdy) m_acc = 1'b1;
          m_age++;
        end
      end
      if (take) mq.push_back(req_t'{we: req_we, addr: req_addr, wdata: req_wdata});
      m_fr = mem_readfin;
      m_fw = mem_writefin;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_on) begin
      chk("m_req_ready",  64'(req_ready),  64'(mq.size() < int'(DEPTH)));
      chk("m_mem_rvalid", 64'(mem_rvalid), 64'(m_busy && !m_acc && !m_cur.we));
      chk("m_mem_wvalid", 64'(mem_wvalid), 64'(m_busy && !m_acc && m_cur.we));
      chk("m_mem_raddr",  mem_raddr,  e_raddr);
      chk("m_mem_waddr",  mem_waddr,  e_waddr);
      chk("m_mem_wdata",  mem_wdata,  e_wdata);
      chk("m_resp_valid", 64'(resp_valid), 64'(m_resp));
      chk("m_resp_we",    64'(resp_we),    64'(e_we));
      chk("m_resp_err",   64'(resp_err),   64'(e_err));
      chk("m_resp_rdata", resp_rdata, e_rdata);
    end
  end

  // Observers used by directed checks.
  int rv_rise = 0;
  bit rv_prev = 1'b0;
  int wacc    = 0;

  always @(negedge clk) begin
    if (mem_rvalid && !rv_prev) rv_rise = cyc;
    rv_prev = mem_rvalid;
  end

  always @(posedge clk) begin
    if (mem_wvalid && mem_write_ready) wacc++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish by 100000 time units");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input logic we, input logic [63:0] a, input logic [63:0] d);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) tfail("push_ready");
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(input bit wr, input string nm);
    int n = 0;
    while (!(wr ? mem_wvalid : mem_rvalid) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) tfail(nm);
  endtask

  task automatic wait_resp(input string nm);
    int n = 0;
    while (!resp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) tfail(nm);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin : stim
    int          t0;
    int          got;
    int          n;
    int          stale;
    int          bad;
    int          wacc0;
    logic        pacc;
    logic [63:0] paddr;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    mem_read_ready = 1'b0; mem_write_ready = 1'b0;
    mem_readfin = 1'b0; mem_writefin = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready",  64'(req_ready),  64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_mem_rvalid", 64'(mem_rvalid), 64'd0);
    chk("rst_mem_raddr",  mem_raddr, 64'd0);

    // Single read; fin rises 5 cycles after acceptance.
    mem_read_ready = 1'b1;
    push(1'b0, 64'h1000, 64'h0);
    t0 = cyc;
    wait_valid(1'b0, "rd_issue");
    chk("rd_issue_latency", 64'(cyc - t0), 64'd1);
    chk("rd_raddr", mem_raddr, 64'h1000);
    @(negedge clk);
    chk("rd_accept_drop", 64'(mem_rvalid), 64'd0);
    repeat (4) @(negedge clk);
    mem_rdata = 64'hDEADBEEF_00000001;
    mem_readfin = 1'b1;
    wait_resp("rd_resp");
    chk("rd_resp_we",    64'(resp_we),  64'd0);
    chk("rd_resp_err",   64'(resp_err), 64'd0);
    chk("rd_resp_rdata", resp_rdata, 64'hDEADBEEF_00000001);
    @(negedge clk);
    chk("rd_resp_pulse", 64'(resp_valid), 64'd0);
    mem_readfin = 1'b0; mem_read_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Write back-pressure for 10 cycles.
    wacc0 = wacc;
    push(1'b1, 64'h2000, 64'h55);
    wait_valid(1'b1, "bp_issue");
    for (int i = 0; i < 10; i++) begin
      chk("bp_wvalid_hold", 64'(mem_wvalid), 64'd1);
      chk("bp_waddr_hold",  mem_waddr, 64'h2000);
      chk("bp_wdata_hold",  mem_wdata, 64'h55);
      @(negedge clk);
    end
    mem_write_ready = 1'b1;
    @(negedge clk);
    mem_write_ready = 1'b0;
    chk("bp_wvalid_drop", 64'(mem_wvalid), 64'd0);
    mem_writefin = 1'b1;
    wait_resp("bp_resp");
    chk("bp_resp_we",    64'(resp_we),  64'd1);
    chk("bp_resp_err",   64'(resp_err), 64'd0);
    chk("bp_resp_rdata", resp_rdata, 64'd0);
    mem_writefin = 1'b0;
    repeat (3) @(negedge clk);
    chk("bp_accept_count", 64'(wacc - wacc0), 64'd1);

    // FIFO full: five reads back-to-back with the model stalled.
    for (int i = 0; i < 5; i++) push(1'b0, 64'h3000 + 64'(i * 8), 64'h0);
    chk("full_req_ready", 64'(req_ready), 64'd0);
    mem_read_ready = 1'b1;
    pacc  = mem_rvalid && mem_read_ready;
    paddr = mem_raddr;
    got = 0; n = 0;
    while (got < 5 && n < 200) begin
      @(negedge clk);
      n++;
      mem_readfin = 1'b0;
      if (pacc) begin
        mem_readfin = 1'b1;
        mem_rdata   = {32'hA5A5A5A5, paddr[31:0]};
      end
      if (resp_valid) begin
        chk("full_order_rdata", resp_rdata, {32'hA5A5A5A5, 32'h3000 + 32'(got * 8)});
        got++;
      end
      pacc  = mem_rvalid && mem_read_ready;
      paddr = mem_raddr;
    end
    if (got < 5) tfail("full_all_resps");
    mem_readfin = 1'b0; mem_read_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Stale fin level must not complete the read.
    mem_readfin = 1'b1; mem_read_ready = 1'b1;
    push(1'b0, 64'h4000, 64'h0);
    wait_valid(1'b0, "stale_issue");
    @(negedge clk);
    stale = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) stale++;
    end
    chk("stale_no_resp", 64'(stale), 64'd0);
    mem_readfin = 1'b0;
    @(negedge clk);
    mem_readfin = 1'b1;
    mem_rdata = 64'h1111_2222_3333_4444;
    wait_resp("stale_resp");
    chk("stale_resp_err",   64'(resp_err), 64'd0);
    chk("stale_resp_rdata", resp_rdata, 64'h1111_2222_3333_4444);
    mem_readfin = 1'b0; mem_read_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Timeout on a read, then the queued write issues.
    push(1'b0, 64'h5000, 64'h0);
    push(1'b1, 64'h6000, 64'h66);
    wait_resp("to_resp");
    chk("to_latency",    64'(cyc - rv_rise), 64'd16);
    chk("to_resp_err",   64'(resp_err), 64'd1);
    chk("to_resp_we",    64'(resp_we),  64'd0);
    chk("to_resp_rdata", resp_rdata, 64'd0);
    t0 = cyc;
    wait_valid(1'b1, "to_next_issue");
    chk("to_next_latency", 64'(cyc - t0), 64'd2);
    chk("to_next_waddr", mem_waddr, 64'h6000);
    mem_write_ready = 1'b1;
    @(negedge clk);
    mem_write_ready = 1'b0;
    mem_writefin = 1'b1;
    wait_resp("to_wr_resp");
    chk("to_wr_resp_err", 64'(resp_err), 64'd0);
    chk("to_wr_resp_we",  64'(resp_we),  64'd1);
    mem_writefin = 1'b0;
    repeat (3) @(negedge clk);

    // Reset while waiting on a write with two more queued.
    mem_write_ready = 1'b1;
    push(1'b1, 64'h7000, 64'h77);
    wait_valid(1'b1, "rst_mid_issue");
    @(negedge clk);
    push(1'b1, 64'h7008, 64'h78);
    push(1'b1, 64'h7010, 64'h79);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_req_ready",  64'(req_ready),  64'd1);
    chk("rst_mid_wvalid",     64'(mem_wvalid), 64'd0);
    chk("rst_mid_rvalid",     64'(mem_rvalid), 64'd0);
    chk("rst_mid_resp_valid", 64'(resp_valid), 64'd0);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) mem_writefin = 1'b1;
      @(negedge clk);
      if (resp_valid || mem_wvalid || mem_rvalid) bad++;
    end
    chk("rst_mid_quiet", 64'(bad), 64'd0);
    mem_writefin = 1'b0; mem_write_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_req_issuer.md
# ram_req_issuer

Request front-end that sits directly upstream of the DPI RAM timing model. It accepts read/write requests from the core side over a valid/ready interface and buffers them in a small FIFO. It issues them one at a time to the model's rvalid/wvalid + readReady/writeReady handshake, waits for readfin/writefin, and returns a single-cycle response with read data or a timeout error.

## Interface
- DEPTH, 4: request FIFO entries; power of two, ≥2.
- TIMEOUT, 1024: maximum cycles in a wait state before an error response; ≥4.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core request present.
- req_ready  out  1  FIFO not full; a transfer occurs when req_valid && req_ready at the edge.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  64  byte address.
- req_wdata  in  64  write data; ignored for reads.
- resp_valid  out  1  one-cycle response pulse.
- resp_we  out  1  type of the completed request.
- resp_err  out  1  1 = request timed out.
- resp_rdata  out  64  read data; 0 for writes and errors.
- mem_rvalid / mem_wvalid  out  1  read/write request to model.
- mem_raddr / mem_waddr / mem_wdata  out  64  request fields to model.
- mem_read_ready / mem_write_ready  in  1  model can accept read/write.
- mem_readfin / mem_writefin  in  1  model completion levels.
- mem_rdata  in  64  model read data.

## Operation
- FIFO:
  - Stores {we, addr, wdata}.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally; full/empty are derived from the MSB compare.
  - req_ready = !full, computed combinationally from registered pointers.
  - Simultaneous push and pop while full is not allowed; req_ready is already 0 when full. A pop while full frees the slot for the next cycle.
  - Simultaneous push and pop while empty is impossible, because pop requires FIFO not empty.
- FSM states: IDLE, ISSUE_RD, WAIT_RD, ISSUE_WR, WAIT_WR, RESP.
  - IDLE: if FIFO not empty, pop the head into the issue registers and go to ISSUE_RD or ISSUE_WR according to we.
  - ISSUE_RD: assert mem_rvalid with mem_raddr = head addr. The request is accepted at the first edge with mem_rvalid && mem_read_ready; then go to WAIT_RD and deassert mem_rvalid the next cycle. ISSUE_WR is the same with mem_wvalid, mem_waddr, mem_wdata and mem_write_ready.
  - WAIT_RD / WAIT_WR: completion is a rising edge of the matching fin input, i.e. fin = 1 and fin_q = 0, where fin_q is fin registered every cycle. A fin level that is already high on entry does not complete the request.
    - On completion, capture mem_rdata (reads) and go to RESP.
  - RESP: drive resp_valid = 1 for exactly one cycle, then return to IDLE.
- Timeout:
  - A counter clears on entering ISSUE_* and increments every cycle in ISSUE_* and WAIT_*.
  - When it reaches TIMEOUT-1 with no completion, go to RESP with resp_err = 1 and resp_rdata = 0. Any pending mem_*valid drops the same cycle.
  - A completion edge in the same cycle as the timeout wins: resp_err = 0.
- Only one request is outstanding; the mem_* address/data outputs hold stable from ISSUE through WAIT.
- An unused-direction valid is always 0; mem_rvalid and mem_wvalid are never both 1.

## Timing
- Reset values: req_ready = 1 (FIFO empty), resp_valid = 0, resp_we = 0, resp_err = 0, resp_rdata = 0, mem_rvalid = 0, mem_wvalid = 0, all mem address/data outputs = 0, state = IDLE, pointers = 0, fin_q = 0, counter = 0.
- Reset asserted mid-transaction:
  - Discards the FIFO contents and the in-flight request.
  - No response is produced.
  - mem_*valid is 0 in the cycle after the reset edge.
- Minimum latency, FIFO empty and ready high:
  - push at edge T; IDLE pops at T+1; mem_*valid is high during T+1..T+2 and accepted at T+2.
  - A fin rise sampled at edge T+3 gives resp_valid during T+3..T+4.
- All outputs are registered except req_ready.
- Throughput is at most one request per 4 cycles.
- fin_q keeps updating in every state, so edges are detected relative to the previous cycle regardless of state.

## Test plan
- Single read:
  - Stimulus: push read addr 0x1000; ready high; readfin rises 5 cycles after acceptance with mem_rdata = 0xDEADBEEF_00000001.
  - Required: one resp_valid, resp_we = 0, resp_err = 0, resp_rdata = 0xDEADBEEF_00000001.
- Back-pressure:
  - Stimulus: mem_write_ready low for 10 cycles while pushing write 0x2000 / 0x55.
  - Required: mem_wvalid is held with stable fields for 10 cycles, accepted on the first ready cycle, and produces exactly one mem_wvalid acceptance.
- FIFO full:
  - Stimulus: push DEPTH+1 = 5 requests back-to-back with the model stalled.
  - Required: req_ready drops after the 4th stored entry (the first one has already been popped to issue); all 5 responses arrive later in order.
- Stale fin:
  - Stimulus: mem_readfin held high before the read is issued.
  - Required: no completion until fin falls and rises again.
- Timeout:
  - Stimulus: TIMEOUT = 16, readfin never rises.
  - Required: resp_valid with resp_err = 1 and resp_rdata = 0 exactly 16 cycles after ISSUE_RD entry; the next queued request then issues.
- Reset mid-WAIT_WR with 2 queued requests:
  - Required: no resp_valid, req_ready = 1, mem_*valid = 0 after the reset edge.
